id_ex_stage: RTL

- Decode-to-execute pipeline register for the RV32 core. Holds the instruction's operands and control fields for the execute stage; these feed the execute-stage register forwarding unit and the ALU.
- Detects load-use hazards and inserts bubbles, stalling decode.
- Applies branch flush and downstream stall.
- Write-through from the W stage keeps latched operands coherent with the register file.

---
 rtl/id_ex_stage.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register for the RV32 core.
// Latches operands and controls into the E slot and detects load-use hazards,
// inserting LOAD_USE_BUBBLES bubbles while stalling decode. It also applies
// flush_E/stall_E and writes W-stage results through into the operands it latches.
// Optional feature macro: BUBBLE_CNT_EN adds the bubble_cnt output and its counter.
module id_ex_stage #(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned XLEN             = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_D,
  input  logic [XLEN-1:0] PC_D,
  input  logic [4:0]      Rs1_D,
  input  logic [4:0]      Rs2_D,
  input  logic [4:0]      Rd_D,
  input  logic [XLEN-1:0] rdata1_D,
  input  logic [XLEN-1:0] rdata2_D,
  input  logic [XLEN-1:0] imme_D,
  input  logic            reg_ren_D,
  input  logic            auipc_D,
  input  logic            ALU_DB_Src_D,
  input  logic            RegWrite_D,
  input  logic            MemRead_D,
  input  logic [3:0]      ALUop_D,
  input  logic            flush_E,
  input  logic            stall_E,
  input  logic            RegWrite_W,
  input  logic [4:0]      Rd_W,
  input  logic [XLEN-1:0] rdata_reg_W,
  output logic            valid_E,
  output logic [XLEN-1:0] PC_reg_E,
  output logic [4:0]      Rs1_E,
  output logic [4:0]      Rs2_E,
  output logic [4:0]      Rd_E,
  output logic [XLEN-1:0] rdata1_E,
  output logic [XLEN-1:0] rdata2_E,
  output logic [XLEN-1:0] imme_E,
  output logic            reg_ren_E,
  output logic            auipc_E,
  output logic            ALU_DB_Src_E,
  output logic            RegWrite_E,
  output logic            MemRead_E,
  output logic [3:0]      ALUop_E,
  output logic            stall_D
`ifdef BUBBLE_CNT_EN
  ,
  output logic [31:0]     bubble_cnt
`endif
);

  typedef enum logic {ST_RUN, ST_BUBBLE} state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imme;
    logic            reg_ren;
    logic            auipc;
    logic            alu_db_src;
    logic            reg_write;
    logic            mem_read;
    logic [3:0]      alu_op;
  } e_slot_t;

  localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_BUBBLES - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  e_slot_t    e_q, e_d;
  e_slot_t    d_entry;
  logic       hz;
  logic       wt1_d, wt2_d, wt1_e, wt2_e;

  // Hazard detect, write-through matches and the candidate D entry.
  // Rs2 is always compared because stores read it too.
  always_comb begin
    hz = e_q.valid & e_q.mem_read & (e_q.rd != '0) & valid_D & reg_ren_D &
         ((Rs1_D == e_q.rd) | (Rs2_D == e_q.rd));
    wt1_d = RegWrite_W & (Rd_W != '0) & (Rd_W == Rs1_D);
    wt2_d = RegWrite_W & (Rd_W != '0) & (Rd_W == Rs2_D);
    wt1_e = RegWrite_W & (Rd_W != '0) & (Rd_W == e_q.rs1);
    wt2_e = RegWrite_W & (Rd_W != '0) & (Rd_W == e_q.rs2);

    d_entry            = '0;
    d_entry.valid      = valid_D;
    d_entry.pc         = PC_D;
    d_entry.rs1        = Rs1_D;
    d_entry.rs2        = Rs2_D;
    d_entry.rd         = Rd_D;
    d_entry.rdata1     = wt1_d ? rdata_reg_W : rdata1_D;
    d_entry.rdata2     = wt2_d ? rdata_reg_W : rdata2_D;
    d_entry.imme       = imme_D;
    d_entry.reg_ren    = reg_ren_D;
    d_entry.auipc      = auipc_D;
    d_entry.alu_db_src = ALU_DB_Src_D;
    d_entry.reg_write  = RegWrite_D;
    d_entry.mem_read   = MemRead_D;
    d_entry.alu_op     = ALUop_D;
  end

  // Next E slot, state and bubble countdown; priority flush > stall > bubble > advance.
  always_comb begin
    e_d     = e_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_D = 1'b0;
    if (flush_E) begin
      e_d     = '0;
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (stall_E) begin
      stall_D = 1'b1;
      if (wt1_e) e_d.rdata1 = rdata_reg_W;
      if (wt2_e) e_d.rdata2 = rdata_reg_W;
    end else if (state_q == ST_BUBBLE) begin
      e_d     = '0;
      stall_D = 1'b1;
      cnt_d   = cnt_q - 2'd1;
      if (cnt_q == 2'd1) state_d = ST_RUN;
    end else if (hz) begin
      e_d     = '0;
      stall_D = 1'b1;
      cnt_d   = CNT_INIT;
      if (LOAD_USE_BUBBLES > 1) state_d = ST_BUBBLE;
    end else begin
      e_d = d_entry;
    end
  end

  // Pipeline register and state machine with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_q     <= '0;
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      e_q     <= e_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        bub_inc;

  // Count load-use bubble cycles and flushes that kill a valid E instruction.
  always_comb begin
    bub_inc = 1'b0;
    if (flush_E) bub_inc = e_q.valid;
    else if (!stall_E) bub_inc = (state_q == ST_BUBBLE) | hz;
    bubble_cnt_d = bubble_cnt_q + 32'(bub_inc);
  end

  // Bubble counter register, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) bubble_cnt_q <= '0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

  assign valid_E      = e_q.valid;
  assign PC_reg_E     = e_q.pc;
  assign Rs1_E        = e_q.rs1;
  assign Rs2_E        = e_q.rs2;
  assign Rd_E         = e_q.rd;
  assign rdata1_E     = e_q.rdata1;
  assign rdata2_E     = e_q.rdata2;
  assign imme_E       = e_q.imme;
  assign reg_ren_E    = e_q.reg_ren;
  assign auipc_E      = e_q.auipc;
  assign ALU_DB_Src_E = e_q.alu_db_src;
  assign RegWrite_E   = e_q.reg_write;
  assign MemRead_E    = e_q.mem_read;
  assign ALUop_E      = e_q.alu_op;

endmodule
